// File: rtl/reaction_timer_core.sv
// Reaction timer control core: random pre-delay, GO indicator, millisecond
// measurement of the player's reaction and early-press fault detection.
// The result is a 20-bit binary millisecond count for the BCD display path.
module reaction_timer_core #(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned MIN_WAIT_MS = 1000,
    parameter int unsigned MAX_MS      = 9999,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    output logic [19:0] time_ms,
    output logic        led_go,
    output logic        result_valid,
    output logic        too_soon,
    output logic        timeout,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_MEASURE = 3'd2,
        S_DONE    = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          start_q;
    logic          stop_q;
    logic          start_p;
    logic          stop_p;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_nxt;
    logic [PW-1:0] presc;
    logic          tick;
    logic          presc_clr;
    logic [19:0]   wait_cnt;
    logic [19:0]   wait_nxt;
    logic [19:0]   wait_load;
    logic [19:0]   time_nxt;
    logic          timeout_nxt;

    // result_valid is a level, not a handshake: it stays high for as long as
    // the core sits in DONE, and time_ms is stable for that whole interval.
    // No acknowledge exists; the next start press simply clears it.

    assign state_dbg = state;
    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign wait_load = 20'(MIN_WAIT_MS) + {8'd0, lfsr[11:0]};

    // Button edge pulses are registered so buttons act one cycle after
    // the edge; the LFSR free-runs in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            start_p <= 1'b0;
            stop_p  <= 1'b0;
            lfsr    <= LFSR_SEED;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            start_p <= start & ~start_q;
            stop_p  <= stop & ~stop_q;
            lfsr    <= lfsr_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decisions; stop has priority in the busy
    // states, start has priority in the idle-like states.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        time_nxt    = time_ms;
        timeout_nxt = timeout;
        case (state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start_p) begin
                    state_nxt   = S_WAIT;
                    wait_nxt    = wait_load;
                    time_nxt    = 20'd0;
                    timeout_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                if (stop_p) begin
                    state_nxt = S_FAULT;
                    time_nxt  = 20'd0;
                end else if (tick) begin
                    if (wait_cnt <= 20'd1) begin
                        state_nxt = S_MEASURE;
                        time_nxt  = 20'd0;
                        wait_nxt  = 20'd0;
                    end else begin
                        wait_nxt = wait_cnt - 20'd1;
                    end
                end
            end
            S_MEASURE: begin
                if (stop_p) begin
                    state_nxt = S_DONE;
                end else if (tick) begin
                    if (time_ms == 20'(MAX_MS - 1)) begin
                        state_nxt   = S_DONE;
                        time_nxt    = 20'(MAX_MS);
                        timeout_nxt = 1'b1;
                    end else begin
                        time_nxt = time_ms + 20'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                time_nxt  = 20'd0;
                wait_nxt  = 20'd0;
                timeout_nxt = 1'b0;
            end
        endcase
    end

    // Restart the ms prescaler on entry to WAIT or MEASURE so the first
    // millisecond is a full tick period.
    always_comb begin
        presc_clr = (state_nxt != state) &&
                    ((state_nxt == S_WAIT) || (state_nxt == S_MEASURE));
    end

    // Registered datapath and flag outputs, decoded from the next state so
    // they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            wait_cnt     <= 20'd0;
            time_ms      <= 20'd0;
            led_go       <= 1'b0;
            result_valid <= 1'b0;
            too_soon     <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            presc        <= (presc_clr || tick) ? '0 : presc + PW'(1);
            wait_cnt     <= wait_nxt;
            time_ms      <= time_nxt;
            led_go       <= (state_nxt == S_MEASURE);
            result_valid <= (state_nxt == S_DONE);
            too_soon     <= (state_nxt == S_FAULT);
            timeout      <= timeout_nxt;
            busy         <= (state_nxt == S_WAIT) || (state_nxt == S_MEASURE);
        end
    end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Self-checking bench for reaction_timer_core with a small tick divider,
// a short minimum wait and a low saturation value.
module tb_reaction_timer_core;

  localparam int TD = 4;
  localparam int MW = 3;
  localparam int MX = 20;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int LIM = 32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [19:0] time_ms;
  logic        led_go;
  logic        result_valid;
  logic        too_soon;
  logic        timeout;
  logic        busy;
  logic [2:0]  state_dbg;

  int n_vec;
  int n_err;
  logic [15:0] m_lfsr;
  logic [19:0] exp_q[$];

  reaction_timer_core #(
    .TICK_DIV(TD), .MIN_WAIT_MS(MW), .MAX_MS(MX), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .time_ms(time_ms), .led_go(led_go), .result_valid(result_valid),
    .too_soon(too_soon), .timeout(timeout), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // reference LFSR: reset to the seed, one step per clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {time_ms, led_go, result_valid, too_soon, timeout, busy, state_dbg}, 32'd0);
  endtask

  // press start at a moment where the sampled LFSR gives a short wait;
  // n returns the expected wait length in ms
  task automatic press_start(output int n);
    logic [15:0] nxt;
    int guard;
    step($urandom_range(0, 7));
    guard = 0;
    forever begin
      nxt = lfsr_next(m_lfsr);
      if (nxt[11:0] < LIM || guard >= 5000) break;
      step(1);
      guard++;
    end
    n = MW + int'(nxt[11:0]);
    start = 1'b1;
  endtask

  // count cycles from the start press until GO; check against the model
  task automatic wait_go(input int n);
    int cyc;
    int limit;
    cyc = 0;
    limit = TD * (MW + LIM) + 20;
    forever begin
      step(1);
      cyc++;
      if (cyc == 2) start = 1'b0;
      if (led_go === 1'b1 || cyc >= limit) break;
      if (cyc >= 3) chk("wait_busy", busy, 1);
    end
    start = 1'b0;
    chk("go_latency", cyc, 2 + TD * n);
    chk("go_time_zero", time_ms, 0);
    chk("go_busy", busy, 1);
    chk("go_no_fault", too_soon, 0);
  endtask

  // press stop w cycles after GO was observed and check the result
  task automatic measure_stop(input int w);
    int t;
    logic exp_to;
    logic [19:0] e;
    step(w);
    stop = 1'b1;
    t = (w + 1) / TD;
    if (t >= MX) begin
      exp_q.push_back(20'(MX));
      exp_to = 1'b1;
    end else begin
      exp_q.push_back(20'(t));
      exp_to = 1'b0;
    end
    step(2);
    e = exp_q.pop_front();
    chk("result_time", time_ms, e);
    chk("result_valid", result_valid, 1);
    chk("result_timeout", timeout, exp_to);
    chk("result_led_off", led_go, 0);
    chk("result_not_busy", busy, 0);
    chk("result_state", state_dbg, 3);
    step(1);
    stop = 1'b0;
    step(1);
  endtask

  // press stop during WAIT; coincide puts the stop on the expiry tick
  task automatic fault_trial(input bit coincide);
    int n;
    int k;
    logic saw_go;
    press_start(n);
    k = coincide ? TD * n : int'($urandom_range(3, TD * n - 1));
    saw_go = 1'b0;
    for (int i = 1; i <= k; i++) begin
      step(1);
      if (i == 2) start = 1'b0;
      saw_go = saw_go | led_go;
    end
    stop = 1'b1;
    step(1);
    saw_go = saw_go | led_go;
    step(1);
    saw_go = saw_go | led_go;
    chk("fault_go_never", saw_go, 0);
    chk("fault_too_soon", too_soon, 1);
    chk("fault_time", time_ms, 0);
    chk("fault_busy", busy, 0);
    chk("fault_state", state_dbg, 4);
    step(2);
    chk("fault_hold_led", led_go, 0);
  endtask

  // saturate at MAX_MS without any stop press
  task automatic timeout_trial();
    step(TD * MX - 1);
    chk("pre_to_time", time_ms, MX - 1);
    chk("pre_to_flag", timeout, 0);
    chk("pre_to_led", led_go, 1);
    step(1);
    chk("to_time", time_ms, MX);
    chk("to_flag", timeout, 1);
    chk("to_valid", result_valid, 1);
    chk("to_led_off", led_go, 0);
    chk("to_busy", busy, 0);
  endtask

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    step(3);
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk_all_zero("idle_hold");
    end

    // basic trial: 7 ms reaction
    press_start(n);
    wait_go(n);
    measure_stop(27);

    // randomized reaction times, some beyond the saturation point
    for (int i = 0; i < 4; i++) begin
      press_start(n);
      wait_go(n);
      measure_stop(int'($urandom_range(0, 95)));
    end

    // stop coincident with a tick after 5 counted ms
    press_start(n);
    wait_go(n);
    measure_stop(TD * 6 - 2);

    // early stop, then a start with stop still held must not fault
    fault_trial(1'b0);
    press_start(n);
    wait_go(n);
    stop = 1'b0;
    measure_stop(int'($urandom_range(1, 60)));

    // stop on the WAIT expiry tick
    fault_trial(1'b1);
    stop = 1'b0;
    step(2);

    // simultaneous start and stop in FAULT: start wins
    press_start(n);
    stop = 1'b1;
    wait_go(n);
    stop = 1'b0;
    timeout_trial();

    // asynchronous reset in the middle of a measurement
    press_start(n);
    wait_go(n);
    step(16);
    chk("pre_reset_time", time_ms, 4);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    step(2);
    rst_n = 1'b1;
    step(3);
    chk_all_zero("post_reset_idle");
    press_start(n);
    wait_go(n);
    measure_stop(int'($urandom_range(1, 60)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
Upstream control stage of the reaction timer. Runs one trial per start press: waits a pseudo-random delay, lights the GO LED, then counts milliseconds until the player presses stop. It presents the result as a 20-bit binary millisecond count that feeds the binary-to-BCD converter and the 4-digit display path. Early presses are flagged as faults.

Parameters:
TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock); minimum 2
MIN_WAIT_MS, 1000, fixed part of the random wait, in ms
MAX_MS, 9999, saturation/timeout value for time_ms (4 BCD digits)
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  start button level, debounced and synchronous to clk
stop  input  1  react button level, debounced and synchronous to clk
time_ms  output  20  result/running count in ms; feeds binary-to-BCD bin input
led_go  output  1  GO indicator; high only in MEASURE
result_valid  output  1  high in DONE; time_ms holds the final result
too_soon  output  1  high in FAULT; stop was pressed before GO
timeout  output  1  high in DONE when the trial ended at MAX_MS without a stop press
busy  output  1  high in WAIT or MEASURE

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; time_ms=0.
  - led_go, result_valid, too_soon, timeout and busy all 0.
  - Prescaler=0, wait counter=0, lfsr=LFSR_SEED, edge registers=0.
- Edge detect: start_p = start & ~start_q; stop_p = stop & ~stop_q. start_q and stop_q are registered every clk. Button levels never act directly; only these pulses do.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk in every state.
- Tick: prescaler counts 0..TICK_DIV-1. tick=1 for one cycle when prescaler==TICK_DIV-1, then the prescaler wraps to 0. The prescaler is forced to 0 on entry to WAIT and to MEASURE, so the first ms is a full TICK_DIV cycles.
- IDLE:
  - start_p -> WAIT.
  - wait_cnt = MIN_WAIT_MS + lfsr[11:0] (range 1000..5095 ms with defaults).
  - time_ms=0; all flags cleared.
- WAIT (busy=1):
  - On each tick, wait_cnt decrements.
  - On a tick with wait_cnt==1 -> MEASURE: led_go=1, time_ms=0.
  - stop_p -> FAULT: too_soon=1, time_ms=0, busy=0.
  - stop_p in the same cycle as the expiry tick: stop wins, go to FAULT.
  - start_p is ignored.
- MEASURE (busy=1, led_go=1):
  - On each tick, time_ms increments.
  - On a tick with time_ms==MAX_MS-1 -> DONE: time_ms=MAX_MS, timeout=1.
  - stop_p -> DONE: time_ms is frozen and not incremented that cycle, result_valid=1, led_go=0.
  - stop_p coincident with a tick: stop wins and no increment happens.
  - start_p is ignored.
- DONE (result_valid=1):
  - time_ms is held.
  - start_p -> WAIT with a new wait_cnt; flags cleared as in IDLE.
  - timeout also sets result_valid=1.
- FAULT (too_soon=1, time_ms=0):
  - start_p -> WAIT as from DONE.
- Simultaneous start_p and stop_p: start wins in IDLE, DONE and FAULT. Stop wins in WAIT and MEASURE.
- A held button produces a single pulse. Holding stop through start_p does not fault until stop is released and pressed again.
- Reset mid-trial: returns immediately to the IDLE reset values, whatever the state.
- All outputs are registered. The latency from a stop edge to the output change is 2 clk: 1 cycle for the edge register plus 1 for the state update.
- time_ms upper bits [19:14] are always 0 while MAX_MS <= 16383.

Test Plan:
- Reset release, TICK_DIV=4, MIN_WAIT_MS=3, then hold idle for 20 clk -> time_ms=0 and all flags 0 throughout.
- start pulse, then after GO wait 7 ticks (28 clk) and press stop -> time_ms=7, result_valid=1, led_go=0. Check that the wait length equals 3 + lfsr[11:0] computed from the seed at the start cycle.
- Press stop during WAIT -> too_soon=1, time_ms=0, busy=0, led_go never asserted. A following start begins a new WAIT.
- MAX_MS=20 and no stop press -> time_ms=20, timeout=1, result_valid=1 exactly 20 ticks after GO.
- Stop pulse aligned with a tick in MEASURE after 5 counted ms -> time_ms=5, not 6. Stop aligned with the WAIT expiry tick -> FAULT.
- rst_n low mid-MEASURE with time_ms=4 -> all outputs 0 and state IDLE immediately, asynchronously. After release, start and stop are honoured normally.
